// File: rtl/stack_btn_ctrl_pkg.sv
// Shared definitions for the LED-stack button front end.
//   - db_state_e : debouncer state encoding
//   - DB_LIMIT_SYN / DB_LIMIT_SIM : default stable-cycle counts for hardware / simulation
package stack_btn_ctrl_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } db_state_e;

  localparam int DB_LIMIT_SYN = 1000000;
  localparam int DB_LIMIT_SIM = 4;

endpackage

// File: rtl/stack_btn_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchroniser followed by a four-state debounce FSM.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   i_btn        : raw asynchronous button level
//   o_level      : debounced level (1 while PRESSED / WAIT_RELEASE)
//   o_rise       : one-cycle pulse on an accepted press
module btn_debounce
  import stack_btn_ctrl_pkg::*;
#(
  parameter int DB_LIMIT = DB_LIMIT_SYN,
  parameter int DB_CNT_W = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam logic [DB_CNT_W-1:0] LIM_M1 = DB_CNT_W'(DB_LIMIT - 1);

  logic                r_sync1, r_sync2;
  db_state_e           r_state, w_state_nxt;
  logic [DB_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                w_cnt_done;

  // Plain two-flop synchroniser, nothing between the stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // >= rather than == keeps the counter pinned even if it ever overshot.
  assign w_cnt_done = (r_cnt >= LIM_M1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_rise      = 1'b0;
    case (r_state)
      RELEASED: if (r_sync2) begin
        w_state_nxt = WAIT_PRESS;
        w_cnt_nxt   = '0;
      end
      WAIT_PRESS: begin
        if (!r_sync2)        w_state_nxt = RELEASED;
        else if (w_cnt_done) begin
          w_state_nxt = PRESSED;
          o_rise      = 1'b1;
        end
        else                 w_cnt_nxt = r_cnt + 1'b1;
      end
      PRESSED: if (!r_sync2) begin
        w_state_nxt = WAIT_RELEASE;
        w_cnt_nxt   = '0;
      end
      WAIT_RELEASE: begin
        if (r_sync2)         w_state_nxt = PRESSED;
        else if (w_cnt_done) w_state_nxt = RELEASED;
        else                 w_cnt_nxt = r_cnt + 1'b1;
      end
      default: w_state_nxt = RELEASED;
    endcase
  end

  assign o_level = (r_state == PRESSED) || (r_state == WAIT_RELEASE);

endmodule

// File: rtl/stack_btn_ctrl.sv
// stack_btn_ctrl: debounces push/pop buttons and turns each accepted press
// into a qualified one-cycle stack command; latches popped data for LEDs.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   btn_push, btn_pop     : raw buttons
//   sw_data               : switch value used as push data
//   full, empty, rd_data  : stack status / top-of-stack word
//   push, pop, w_data     : registered stack commands and write data
//   led_data              : last popped word
//   led_full, led_empty   : registered status copies
//   err                   : one-cycle pulse on a rejected command
module stack_btn_ctrl
  import stack_btn_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DB_LIMIT = DB_LIMIT_SYN,
  parameter int DB_CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_push,
  input  logic             btn_pop,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             full,
  input  logic             empty,
  input  logic [WIDTH-1:0] rd_data,
  output logic             push,
  output logic             pop,
  output logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] led_data,
  output logic             led_full,
  output logic             led_empty,
  output logic             err
);

  localparam int NUM_BTN = 2;  // [0] = push, [1] = pop

  logic [NUM_BTN-1:0] w_raw, w_rise;
  logic               w_push_ok, w_pop_ok, w_reject;

  assign w_raw = {btn_pop, btn_push};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(
      .DB_LIMIT (DB_LIMIT),
      .DB_CNT_W (DB_CNT_W)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .i_btn   (w_raw[g]),
      .o_level (),
      .o_rise  (w_rise[g])
    );
  end

  // Simultaneous presses are ambiguous, so both are rejected.
  assign w_push_ok = w_rise[0] & ~w_rise[1] & ~full;
  assign w_pop_ok  = w_rise[1] & ~w_rise[0] & ~empty;
  assign w_reject  = (w_rise[0] & w_rise[1])
                   | (w_rise[0] & ~w_rise[1] & full)
                   | (w_rise[1] & ~w_rise[0] & empty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push      <= 1'b0;
      pop       <= 1'b0;
      err       <= 1'b0;
      w_data    <= '0;
      led_data  <= '0;
      led_full  <= 1'b0;
      led_empty <= 1'b1;
    end else begin
      push      <= w_push_ok;
      pop       <= w_pop_ok;
      err       <= w_reject;
      led_full  <= full;
      led_empty <= empty;
      if (w_push_ok) w_data <= sw_data;
      // rd_data is still the pre-pop top while pop is high.
      if (pop)       led_data <= rd_data;
    end
  end

endmodule
